// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   ID-stage branch resolution with operand forwarding, load-use stall,
//   six MIPS branch conditions, a 2-bit saturating branch history table for
//   IF-stage prediction, and a registered redirect on misprediction.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   if_pc / pred_taken            IF-stage BHT lookup (combinational)
//   br_valid, br_op, br_pred      branch in ID, condition code, IF prediction
//   br_pc, br_target              branch PC and taken target
//   read_data1/2                  register-file operands
//   ex_alu_out, mem_alu_out,      forwarding sources and their validity
//   wb_data, ex_ready, mem_ready
//   fwd_rs, fwd_rt                operand selects (00 RF, 01 MEM, 10 EX, 11 WB)
//   stall                         combinational hold of IF/ID
//   resolve_valid, taken,         registered resolution results
//   redirect, redirect_pc
//   branch_cnt, mispredict_cnt    free-running statistics counters
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              br_valid,
    input  logic [2:0]        br_op,
    input  logic              br_pred,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [PC_W-1:0]   br_target,
    input  logic [WIDTH-1:0]  read_data1,
    input  logic [WIDTH-1:0]  read_data2,
    input  logic [WIDTH-1:0]  ex_alu_out,
    input  logic [WIDTH-1:0]  mem_alu_out,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              ex_ready,
    input  logic              mem_ready,
    input  logic [1:0]        fwd_rs,
    input  logic [1:0]        fwd_rt,
    output logic              stall,
    output logic              resolve_valid,
    output logic              taken,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [31:0]       branch_cnt,
    output logic [31:0]       mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLEZ = 3'b010;
    localparam logic [2:0] OP_BGTZ = 3'b011;
    localparam logic [2:0] OP_BLTZ = 3'b100;
    localparam logic [2:0] OP_BGEZ = 3'b101;

    // Saturating 2-bit counter step (00..11).
    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? ctr : ctr - 2'b01;
        end
        return res;
    endfunction

    logic [0:0]        state_q, state_d;
    logic [1:0]        bht_q [BHT_DEPTH];
    logic              resolve_valid_q, resolve_valid_d;
    logic              taken_q, taken_d;
    logic              redirect_q, redirect_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]       branch_cnt_q, branch_cnt_d;
    logic [31:0]       mispredict_cnt_q, mispredict_cnt_d;

    logic [WIDTH-1:0]  num1_s, num2_s;
    logic              rs_ready_s, rt_ready_s, uses_rt_s, ops_ready_s;
    logic              cond_s, num1_zero_s, resolve_s;
    logic [IDX_W-1:0]  upd_idx_s;
    logic              unused_pc_bits_s;

    assign unused_pc_bits_s = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                                br_pc[PC_W-1:IDX_W+2], br_pc[1:0]};

    // Operand forwarding muxes and per-operand readiness.
    always_comb begin
        num1_s     = read_data1;
        num2_s     = read_data2;
        rs_ready_s = 1'b1;
        rt_ready_s = 1'b1;
        case (fwd_rs)
            2'b00:   num1_s = read_data1;
            2'b01:   begin num1_s = mem_alu_out; rs_ready_s = mem_ready; end
            2'b10:   begin num1_s = ex_alu_out;  rs_ready_s = ex_ready;  end
            2'b11:   num1_s = wb_data;
            default: num1_s = read_data1;
        endcase
        case (fwd_rt)
            2'b00:   num2_s = read_data2;
            2'b01:   begin num2_s = mem_alu_out; rt_ready_s = mem_ready; end
            2'b10:   begin num2_s = ex_alu_out;  rt_ready_s = ex_ready;  end
            2'b11:   num2_s = wb_data;
            default: num2_s = read_data2;
        endcase
    end

    // Only beq/bne compare two registers; the rest look at num1 alone.
    assign uses_rt_s   = (br_op == OP_BEQ) || (br_op == OP_BNE);
    assign ops_ready_s = rs_ready_s && (rt_ready_s || !uses_rt_s);
    assign stall       = br_valid && !ops_ready_s;
    assign resolve_s   = br_valid && ops_ready_s;
    assign num1_zero_s = (num1_s == {WIDTH{1'b0}});
    assign upd_idx_s   = br_pc[IDX_W+1:2];

    // Branch condition evaluation; unused encodings resolve not taken.
    always_comb begin
        cond_s = 1'b0;
        case (br_op)
            OP_BEQ:  cond_s = (num1_s == num2_s);
            OP_BNE:  cond_s = (num1_s != num2_s);
            OP_BLEZ: cond_s = num1_s[WIDTH-1] || num1_zero_s;
            OP_BGTZ: cond_s = !num1_s[WIDTH-1] && !num1_zero_s;
            OP_BLTZ: cond_s = num1_s[WIDTH-1];
            OP_BGEZ: cond_s = !num1_s[WIDTH-1];
            default: cond_s = 1'b0;
        endcase
    end

    // Pending-branch FSM; a dropped br_valid in WAIT means ID was flushed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = stall ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                if (!br_valid || ops_ready_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the resolution outputs and statistics counters.
    always_comb begin
        resolve_valid_d  = 1'b0;
        redirect_d       = 1'b0;
        taken_d          = taken_q;
        redirect_pc_d    = redirect_pc_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (resolve_s) begin
            resolve_valid_d = 1'b1;
            taken_d         = cond_s;
            redirect_d      = cond_s ^ br_pred;
            redirect_pc_d   = cond_s ? br_target
                                     : br_pc + {{(PC_W-3){1'b0}}, 3'b100};
            branch_cnt_d    = branch_cnt_q + 32'd1;
            if (cond_s ^ br_pred) begin
                mispredict_cnt_d = mispredict_cnt_q + 32'd1;
            end else begin
                mispredict_cnt_d = mispredict_cnt_q;
            end
        end else begin
            resolve_valid_d = 1'b0;
        end
    end

    // State, output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            resolve_valid_q  <= 1'b0;
            taken_q          <= 1'b0;
            redirect_q       <= 1'b0;
            redirect_pc_q    <= {PC_W{1'b0}};
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            resolve_valid_q  <= resolve_valid_d;
            taken_q          <= taken_d;
            redirect_q       <= redirect_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // BHT: reset to weakly-not-taken, trained on every resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (resolve_s) begin
            bht_q[upd_idx_s] <= sat_step(bht_q[upd_idx_s], cond_s);
        end else begin
            bht_q[upd_idx_s] <= bht_q[upd_idx_s];
        end
    end

    // Lookup reads the registered table, so a same-cycle update is not seen.
    assign pred_taken     = bht_q[if_pc[IDX_W+1:2]][1];

    assign resolve_valid  = resolve_valid_q;
    assign taken          = taken_q;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Directed-vector bench for branch_resolve_unit with hand-computed expected
//   values. Inputs change 2 time units after a rising edge; combinational
//   outputs are checked 1 unit later and registered outputs right after the
//   edge that should have updated them.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        br_valid;
    logic [2:0]  br_op;
    logic        br_pred;
    logic [31:0] br_pc, br_target;
    logic [31:0] read_data1, read_data2;
    logic [31:0] ex_alu_out, mem_alu_out, wb_data;
    logic        ex_ready, mem_ready;
    logic [1:0]  fwd_rs, fwd_rt;
    logic        stall, resolve_valid, taken, redirect;
    logic [31:0] redirect_pc, branch_cnt, mispredict_cnt;

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_unit #(.WIDTH(32), .PC_W(32), .BHT_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .br_valid(br_valid), .br_op(br_op), .br_pred(br_pred),
        .br_pc(br_pc), .br_target(br_target),
        .read_data1(read_data1), .read_data2(read_data2),
        .ex_alu_out(ex_alu_out), .mem_alu_out(mem_alu_out), .wb_data(wb_data),
        .ex_ready(ex_ready), .mem_ready(mem_ready),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall(stall),
        .resolve_valid(resolve_valid), .taken(taken), .redirect(redirect),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Program a branch in ID with register-file operands.
    task automatic set_br(input logic [2:0] op, input logic pred,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [31:0] a, input logic [31:0] b);
        br_valid   = 1'b1;
        br_op      = op;
        br_pred    = pred;
        br_pc      = pc;
        br_target  = tgt;
        read_data1 = a;
        read_data2 = b;
    endtask

    // Check the registered outcome of a resolve.
    task automatic chk_res(input string tag, input logic tk, input logic rd,
                           input logic [31:0] rpc, input logic [31:0] bc,
                           input logic [31:0] mc);
        chk({tag, ".rv"},  {31'd0, resolve_valid}, 32'd1);
        chk({tag, ".tk"},  {31'd0, taken}, {31'd0, tk});
        chk({tag, ".rd"},  {31'd0, redirect}, {31'd0, rd});
        chk({tag, ".rpc"}, redirect_pc, rpc);
        chk({tag, ".bc"},  branch_cnt, bc);
        chk({tag, ".mc"},  mispredict_cnt, mc);
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'h0; br_valid = 1'b0; br_op = 3'b000; br_pred = 1'b0;
        br_pc = 32'h0; br_target = 32'h0; read_data1 = 32'h0; read_data2 = 32'h0;
        ex_alu_out = 32'h0; mem_alu_out = 32'h0; wb_data = 32'h0;
        ex_ready = 1'b1; mem_ready = 1'b1; fwd_rs = 2'b00; fwd_rt = 2'b00;
        step(); step();

        // Reset state
        chk("rst.rv",  {31'd0, resolve_valid}, 32'd0);
        chk("rst.tk",  {31'd0, taken}, 32'd0);
        chk("rst.rd",  {31'd0, redirect}, 32'd0);
        chk("rst.rpc", redirect_pc, 32'd0);
        chk("rst.bc",  branch_cnt, 32'd0);
        chk("rst.mc",  mispredict_cnt, 32'd0);
        rst = 1'b0;
        if_pc = 32'h40;
        settle();
        chk("rst.pred40", {31'd0, pred_taken}, 32'd0);
        step();

        // beq forwarded from EX, 5 == 5, predicted not taken
        set_br(3'b000, 1'b0, 32'h100, 32'h200, 32'h0, 32'h5);
        fwd_rs = 2'b10; ex_alu_out = 32'h5;
        settle();
        chk("beq.stall", {31'd0, stall}, 32'd0);
        step();
        br_valid = 1'b0; fwd_rs = 2'b00;
        chk_res("beq", 1'b1, 1'b1, 32'h200, 32'd1, 32'd1);
        step();
        chk("beq.rv_off", {31'd0, resolve_valid}, 32'd0);
        chk("beq.rd_off", {31'd0, redirect}, 32'd0);
        chk("beq.tk_hold", {31'd0, taken}, 32'd1);

        // bne with rt from MEM, load pending for 2 cycles; 7 != 9
        set_br(3'b001, 1'b1, 32'h300, 32'h380, 32'h7, 32'h0);
        fwd_rt = 2'b01; mem_alu_out = 32'h9; mem_ready = 1'b0;
        settle();
        chk("bne.stall1", {31'd0, stall}, 32'd1);
        step();
        chk("bne.stall2", {31'd0, stall}, 32'd1);
        chk("bne.rv_wait", {31'd0, resolve_valid}, 32'd0);
        step();
        mem_ready = 1'b1;
        settle();
        chk("bne.stall3", {31'd0, stall}, 32'd0);
        step();
        br_valid = 1'b0;
        chk_res("bne", 1'b1, 1'b0, 32'h380, 32'd2, 32'd1);
        step();
        chk("bne.rv_once", {31'd0, resolve_valid}, 32'd0);

        // Reset asserted while stalled in WAIT
        set_br(3'b000, 1'b0, 32'h500, 32'h600, 32'h1, 32'h1);
        fwd_rs = 2'b10; fwd_rt = 2'b00; ex_ready = 1'b0;
        step();
        chk("mrst.stall_pre", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        settle();
        chk("mrst.bc_async", branch_cnt, 32'd0);
        step();
        rst = 1'b0; br_valid = 1'b0; ex_ready = 1'b1; fwd_rs = 2'b00;
        if_pc = 32'h100;
        settle();
        chk("mrst.stall", {31'd0, stall}, 32'd0);
        chk("mrst.bht_reset", {31'd0, pred_taken}, 32'd0);
        step();
        chk("mrst.rv", {31'd0, resolve_valid}, 32'd0);
        chk("mrst.tk", {31'd0, taken}, 32'd0);
        chk("mrst.rpc", redirect_pc, 32'd0);
        chk("mrst.mc", mispredict_cnt, 32'd0);

        // Single-operand conditions back to back; rt select to EX must not stall
        fwd_rt = 2'b10; ex_ready = 1'b0;
        set_br(3'b100, 1'b1, 32'h400, 32'h500, 32'h8000_0000, 32'h0);
        settle();
        chk("bltz.nostall", {31'd0, stall}, 32'd0);
        step();
        chk_res("bltz", 1'b1, 1'b0, 32'h500, 32'd1, 32'd0);
        set_br(3'b010, 1'b0, 32'h410, 32'h600, 32'h0, 32'h0);
        step();
        chk_res("blez0", 1'b1, 1'b1, 32'h600, 32'd2, 32'd1);
        set_br(3'b011, 1'b0, 32'h420, 32'h700, 32'h0, 32'h0);
        step();
        chk_res("bgtz0", 1'b0, 1'b0, 32'h424, 32'd3, 32'd1);
        set_br(3'b111, 1'b1, 32'h430, 32'h800, 32'h5, 32'h5);
        step();
        chk_res("op111", 1'b0, 1'b1, 32'h434, 32'd4, 32'd2);
        set_br(3'b101, 1'b0, 32'h440, 32'h900, 32'h7fff_ffff, 32'h0);
        step();
        chk_res("bgez", 1'b1, 1'b1, 32'h900, 32'd5, 32'd3);
        br_valid = 1'b0; fwd_rt = 2'b00; ex_ready = 1'b1;
        step();

        // BHT training at 0x104: 01 -> 10 -> 11 -> 11 -> 11, then two not-taken
        if_pc = 32'h104;
        set_br(3'b000, 1'b0, 32'h104, 32'h200, 32'h3, 32'h3);
        settle();
        chk("bht.rbw", {31'd0, pred_taken}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bht.up%0d", i), {31'd0, pred_taken}, 32'd1);
        end
        set_br(3'b001, 1'b0, 32'h104, 32'h200, 32'h3, 32'h3);
        step();
        chk("bht.dn1", {31'd0, pred_taken}, 32'd1);
        step();
        chk("bht.dn2", {31'd0, pred_taken}, 32'd0);
        chk("bht.bc", branch_cnt, 32'd11);
        chk("bht.mc", mispredict_cnt, 32'd7);

        // Not-taken at top of address space: fall-through wraps to 0
        set_br(3'b001, 1'b1, 32'hFFFF_FFFC, 32'h10, 32'h3, 32'h3);
        step();
        br_valid = 1'b0;
        chk_res("wrap", 1'b0, 1'b1, 32'h0, 32'd12, 32'd8);

        // Flush while waiting: no resolve, counters unchanged
        set_br(3'b000, 1'b0, 32'h700, 32'h780, 32'h1, 32'h1);
        fwd_rt = 2'b10; ex_ready = 1'b0;
        step();
        br_valid = 1'b0;
        step();
        chk("flush.rv", {31'd0, resolve_valid}, 32'd0);
        chk("flush.bc", branch_cnt, 32'd12);
        settle();
        chk("flush.stall", {31'd0, stall}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

ID-stage branch resolution unit for the pipelined MIPS datapath. It is the parametrised successor of the single-mode equality comparator. It forwards both operands from EX, MEM or WB and evaluates six MIPS branch conditions. It stalls ID while a forwarded operand is not yet valid, keeps a 2-bit saturating branch history table (BHT) for IF-stage prediction, and issues a registered redirect on a misprediction.

## Interface
Parameters:
- WIDTH, 32: operand width.
- PC_W, 32: PC width.
- BHT_DEPTH, 16: BHT entries; must be a power of two, ≥2. IDX_W = log2(BHT_DEPTH).

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  PC_W  IF-stage PC used for the BHT lookup.
- pred_taken  out  1  combinational prediction for if_pc: BHT[if_pc[IDX_W+1:2]][1].
- br_valid  in  1  branch instruction present in ID.
- br_op  in  3  branch condition: 000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez; 110/111 evaluate as not taken.
- br_pred  in  1  prediction carried with the branch from IF.
- br_pc, br_target  in  PC_W  branch PC and taken target.
- read_data1, read_data2  in  WIDTH  register-file operands.
- ex_alu_out, mem_alu_out, wb_data  in  WIDTH  forwarding sources.
- ex_ready, mem_ready  in  1  the EX / MEM source value is valid (low while a load result is pending).
- fwd_rs, fwd_rt  in  2  operand select: 00 register file, 01 MEM, 10 EX, 11 WB.
- stall  out  1  combinational; holds IF/ID.
- resolve_valid  out  1  registered one-cycle pulse per resolved branch.
- taken  out  1  registered outcome.
- redirect  out  1  registered; pulses with resolve_valid when the outcome ≠ br_pred.
- redirect_pc  out  PC_W  registered: br_target if taken, else br_pc+4.
- branch_cnt, mispredict_cnt  out  32  free-running resolved and mispredicted counts; wrap at 2^32.

## Operation
- Operand selection: num1 comes from fwd_rs and num2 from fwd_rt per the encoding above.
- Readiness:
  - A select of 10 requires ex_ready and a select of 01 requires mem_ready.
  - Selects 00 and 11 are always ready.
  - blez, bgtz, bltz and bgez use num1 only; num2's readiness is ignored for them.
- stall = br_valid & !ops_ready. The upstream pipeline holds all br_* inputs constant while stall is high.
- Conditions:
  - beq: num1 == num2.
  - bne: num1 != num2.
  - blez: signed num1 ≤ 0.
  - bgtz: signed num1 > 0.
  - bltz: num1[WIDTH-1].
  - bgez: !num1[WIDTH-1].
- Resolve event: br_valid & ops_ready. On that clock edge:
  - Register taken and redirect_pc.
  - Set resolve_valid=1.
  - Set redirect = taken ^ br_pred.
  - Increment branch_cnt, and mispredict_cnt when redirect is set.
  - Update BHT[br_pc[IDX_W+1:2]]: saturating +1 if taken, −1 if not (range 00..11).
- State machine:
  - IDLE: no pending branch.
  - WAIT: br_valid with operands not ready. Stay while not ready; resolve and return to IDLE when ready.
  - br_valid dropping in WAIT returns to IDLE with no resolve (ID flushed).
  - The state is observable only through stall. Back-to-back resolves in consecutive cycles are legal.
- redirect_pc addition is modulo 2^PC_W.

## Timing
- Reset values:
  - resolve_valid, taken and redirect are 0.
  - redirect_pc, branch_cnt and mispredict_cnt are 0.
  - Every BHT entry is 01 (weakly not taken); FSM is in IDLE.
- Reset asserted mid-stall: immediately clears all state. No resolve pulse after release until a new resolve event.
- Latency:
  - Outcome and redirect appear 1 cycle after the resolve edge.
  - Each stall cycle adds 1 cycle.
  - stall and pred_taken are combinational (0 cycles).
- Outputs that are not pulses hold their last value. resolve_valid and redirect are low in every cycle without a new resolve.
- Lookup and update of the same BHT index in the same cycle: pred_taken returns the pre-update value (read-before-write).

## Test plan
- Reset, then if_pc=0x40 → pred_taken=0. Reset mid-stall (WAIT, ex_ready=0) → stall drops once rst is released and br_valid is deasserted, all outputs 0.
- beq with fwd_rs=10, ex_alu_out=5, read_data2=5, br_pred=0, br_pc=0x100, br_target=0x200 → next cycle: resolve_valid=1, taken=1, redirect=1, redirect_pc=0x200, mispredict_cnt=1.
- bne with fwd_rt=01, mem_ready=0 for 2 cycles → stall=1 for exactly 2 cycles. Third cycle resolves with mem_alu_out; resolve_valid pulses once.
- bltz with num1=0x80000000 → taken=1. blez with 0 → taken=1. bgtz with 0 → taken=0. br_op=111 → taken=0. bltz with fwd_rt=10 and ex_ready=0 → no stall.
- Four taken resolves at br_pc=0x104 → BHT entry walks 01→10→11→11, and pred_taken=1 for if_pc=0x104. Lookup during the first update reads 0.
- Not-taken branch at br_pc=0xFFFFFFFC with br_pred=1 → redirect=1, redirect_pc=0x00000000 (wrap).
